// File: rtl/alu_mult_div.sv
// alu_mult_div: multi-cycle EX-stage ALU for the MIPS datapath.
//   Single-cycle logic/arith ops produce a registered result one cycle after
//   acceptance. MULT/MULTU/DIV/DIVU run an iterative shift-add / restoring
//   divide on operand magnitudes and write HI/LO. MFHI/MFLO read them back.
//   Optional feature macro: ALU_OVF_EN adds a registered signed-overflow flag.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   inicio, ALUcontrol  request strobe and 4-bit op code
//   entradaA, entradaB  operands (captured at acceptance)
//   ocupado             high while a MULT/DIV is in flight
//   pronto              one-cycle completion pulse
//   ALUsaida, Zero      registered result and its zero flag
//   hi, lo              HI/LO registers
//   overflow            (ALU_OVF_EN only) signed ADD/SUB overflow
module alu_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] entradaA,
  input  logic [WIDTH-1:0] entradaB,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH-1:0] ALUsaida,
  output logic             Zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] MULT   = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] AJUSTE = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo;  // product, or remainder/quotient
  logic [WIDTH-1:0] m_r;             // multiplicand or divisor magnitude
  logic [WIDTH-1:0] opa_r;           // raw dividend, needed for divide-by-zero
  logic             na_r, nb_r, mul_r;

  // ---------------- request decode ----------------
  logic             is_long, long_sgn, in_na, in_nb;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  assign is_long  = (ALUcontrol[3:2] == 2'b10);
  assign long_sgn = ~ALUcontrol[0];
  assign in_na    = long_sgn & entradaA[WIDTH-1];
  assign in_nb    = long_sgn & entradaB[WIDTH-1];
  assign in_mag_a = in_na ? (~entradaA + 1'b1) : entradaA;
  assign in_mag_b = in_nb ? (~entradaB + 1'b1) : entradaB;

  // ---------------- single-cycle ops ----------------
  logic [WIDTH-1:0] sum, dif, res;
  assign sum = entradaA + entradaB;
  assign dif = entradaA - entradaB;

  always_comb begin
    res = '0;
    case (ALUcontrol)
      OP_AND:  res = entradaA & entradaB;
      OP_OR:   res = entradaA | entradaB;
      OP_XOR:  res = entradaA ^ entradaB;
      OP_NOR:  res = ~(entradaA | entradaB);
      OP_ADD:  res = sum;
      OP_SUB:  res = dif;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(entradaA) < $signed(entradaB))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (entradaA < entradaB)};
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (ALUcontrol == OP_ADD)
      ovf = (entradaA[WIDTH-1] == entradaB[WIDTH-1]) && (sum[WIDTH-1] != entradaA[WIDTH-1]);
    else if (ALUcontrol == OP_SUB)
      ovf = (entradaA[WIDTH-1] != entradaB[WIDTH-1]) && (dif[WIDTH-1] != entradaA[WIDTH-1]);
  end
`endif

  // ---------------- iteration datapath ----------------
  // Shift-add: multiplier sits in acc_lo, LSB selects whether to add the
  // multiplicand into the upper half, then the whole pair shifts right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? m_r : '0)};

  // Restoring divide: dividend shifts out of acc_lo into the remainder,
  // quotient bits shift into acc_lo from the bottom.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, m_r});
  assign div_rem   = div_shift[WIDTH-1:0] - m_r;  // exact: true difference < divisor

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   q_neg, r_neg;
  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = ~prod + 1'b1;
  assign q_neg    = ~acc_lo + 1'b1;
  assign r_neg    = ~acc_hi + 1'b1;

  assign ocupado = (state != OCIOSO);
  assign Zero    = (ALUsaida == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OCIOSO;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      m_r      <= '0;
      opa_r    <= '0;
      na_r     <= 1'b0;
      nb_r     <= 1'b0;
      mul_r    <= 1'b0;
      ALUsaida <= '0;
      hi       <= '0;
      lo       <= '0;
      pronto   <= 1'b0;
`ifdef ALU_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: if (inicio) begin
`ifdef ALU_OVF_EN
          overflow <= is_long ? 1'b0 : ovf;
`endif
          if (is_long) begin
            state  <= ALUcontrol[1] ? DIV : MULT;
            cnt    <= '0;
            opa_r  <= entradaA;
            na_r   <= in_na;
            nb_r   <= in_nb;
            mul_r  <= ~ALUcontrol[1];
            acc_hi <= '0;
            if (ALUcontrol[1]) begin
              m_r    <= in_mag_b;
              acc_lo <= in_mag_a;
            end else begin
              m_r    <= in_mag_a;
              acc_lo <= in_mag_b;
            end
          end else begin
            ALUsaida <= res;
            pronto   <= 1'b1;
          end
        end
        MULT: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= AJUSTE;
        end
        DIV: begin
          acc_hi <= div_ge ? div_rem : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= AJUSTE;
        end
        AJUSTE: begin
          if (mul_r) begin
            {hi, lo} <= (na_r ^ nb_r) ? prod_neg : prod;
          end else if (m_r == '0) begin
            lo <= '1;
            hi <= opa_r;
          end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo <= (na_r ^ nb_r) ? q_neg : acc_lo;
            hi <= na_r ? r_neg : acc_hi;
          end
          pronto <= 1'b1;
          state  <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_div.sv
module tb_alu_mult_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inicio;
  logic [3:0]   ALUcontrol;
  logic [W-1:0] entradaA, entradaB;
  logic         ocupado, pronto, Zero;
  logic [W-1:0] ALUsaida, hi, lo;
`ifdef ALU_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  alu_mult_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .ALUcontrol(ALUcontrol),
    .entradaA(entradaA), .entradaB(entradaB), .ocupado(ocupado),
    .pronto(pronto), .ALUsaida(ALUsaida), .Zero(Zero), .hi(hi), .lo(lo)
`ifdef ALU_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves inicio high across exactly one rising edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUcontrol = op; entradaA = a; entradaB = b; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  // MULT/DIV: checks busy, latency (edges from acceptance to pronto), HI/LO.
  // Scrambles the operands after acceptance and fires an ADD while busy.
  task automatic run_long(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic [W-1:0] esaida);
    int n;
    issue(op, a, b);
    check({tag, "_busy"}, 64'(ocupado), 64'd1);
    ALUcontrol = 4'b0010; entradaA = 32'd1; entradaB = 32'd1; inicio = 1'b1;
    n = 1;
    @(negedge clk);
    inicio = 1'b0; entradaA = 32'hDEAD_BEEF; entradaB = 32'h1234_5678;
    while (!pronto && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_done_idle"}, 64'(ocupado), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_saida_kept"}, 64'(ALUsaida), 64'(esaida));
  endtask

  initial begin
    int np;
    rst_n = 1'b0; inicio = 1'b0; ALUcontrol = '0; entradaA = '0; entradaB = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_saida", 64'(ALUsaida), 64'd0);
    check("rst_zero", 64'(Zero), 64'd1);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {62'd0, pronto, ocupado}, 64'd0);

    issue(4'b0010, 32'd7, 32'd5);
    check("add", 64'(ALUsaida), 64'd12);
    check("add_zero", 64'(Zero), 64'd0);
    check("add_pronto", 64'(pronto), 64'd1);
    check("add_busy", 64'(ocupado), 64'd0);
    @(negedge clk);
    check("pronto_pulse", 64'(pronto), 64'd0);

    issue(4'b0110, 32'd5, 32'd5);
    check("sub", 64'(ALUsaida), 64'd0);
    check("sub_zero", 64'(Zero), 64'd1);
    issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and", 64'(ALUsaida), 64'h00F0_1200);
    issue(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("or", 64'(ALUsaida), 64'hFFF0_FF34);
    issue(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("xor", 64'(ALUsaida), 64'hFF00_ED34);
    issue(4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("nor", 64'(ALUsaida), 64'h000F_00CB);
    issue(4'b0110, 32'd3, 32'd5);
    check("sub_wrap", 64'(ALUsaida), 64'hFFFF_FFFE);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check("slt", 64'(ALUsaida), 64'd1);
    issue(4'b0101, 32'hFFFF_FFFF, 32'd1);
    check("sltu", 64'(ALUsaida), 64'd0);
    issue(4'b0010, 32'd7, 32'd5);
    issue(4'b1111, 32'd7, 32'd5);
    check("undef_op", 64'(ALUsaida), 64'd0);
    issue(4'b0010, 32'd7, 32'd5);

    run_long("mult", 4'b1000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd12);
    issue(4'b1110, 32'd0, 32'd0);
    check("mflo", 64'(ALUsaida), 64'hFFFF_FFF1);
    issue(4'b1101, 32'd0, 32'd0);
    check("mfhi", 64'(ALUsaida), 64'hFFFF_FFFF);

    run_long("multu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF);
    run_long("mult_mix", 4'b1000, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FD44, 32'hFFFF_FFFF);
    run_long("div", 4'b1010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_long("divu0", 4'b1011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_long("div0_s", 4'b1010, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_long("div_minneg", 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_long("divu", 4'b1011, 32'd100, 32'd7, 32'd2, 32'd14, 32'hFFFF_FFFF);
    run_long("divu_big", 4'b1011, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 32'hFFFF_FFFF);

    // Abort a MULT partway through with reset.
    issue(4'b1000, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(ocupado), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_saida", 64'(ALUsaida), 64'd0);
    np = 0;
    repeat (40) begin
      @(negedge clk);
      if (pronto) np++;
    end
    check("abort_no_pronto", 64'(np), 64'd0);

`ifdef ALU_OVF_EN
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    check("ovf_add_res", 64'(ALUsaida), 64'h8000_0000);
    check("ovf_add", 64'(overflow), 64'd1);
    issue(4'b0010, 32'd1, 32'd1);
    check("ovf_none", 64'(overflow), 64'd0);
    issue(4'b0110, 32'h8000_0000, 32'd1);
    check("ovf_sub", 64'(overflow), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
